ratio_divider: RTL

RATIO_DIVIDER -- requirements
Module: ratio_divider

---
 rtl/error_path_pkg.sv | 19 +
 rtl/ratio_divider.sv | 138 +++++++++++++
 2 files changed

// File: rtl/error_path_pkg.sv
// Shared widths, FSM encoding and Q2.24 saturation limits for the ratio divider.
package error_path_pkg;

    localparam int IN_WIDTH   = 32;
    localparam int DATA_WIDTH = 26;
    localparam int FRAC_BITS  = 24;
    localparam int OUT_WIDTH  = 32;
    localparam int CNT_WIDTH  = 5;

    localparam logic [DATA_WIDTH-1:0] Q_MAX = 26'h1FFFFFF;
    localparam logic [DATA_WIDTH-1:0] Q_MIN = 26'h2000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ratio_divider.sv
// Signed diff/sum ratio in Q2.24 via a bit-serial restoring divider.
// Fixed 26-cycle latency from accept to result, including saturation and divide-by-zero.
module ratio_divider #(
    parameter int IN_WIDTH   = error_path_pkg::IN_WIDTH,
    parameter int DATA_WIDTH = error_path_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = error_path_pkg::FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*IN_WIDTH-1:0] S_AXIS_in_tdata,
    input  logic                  S_AXIS_in_tvalid,
    output logic                  S_AXIS_in_tready,
    output logic [31:0]           M_AXIS_out_tdata,
    output logic                  M_AXIS_out_tvalid,
    output logic                  sat_flag,
    output logic                  div0_flag
);
    import error_path_pkg::*;

    localparam int MAG_W = IN_WIDTH + 1;
    localparam int REM_W = IN_WIDTH + 2;
    localparam int QUO_W = FRAC_BITS + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(FRAC_BITS);

    state_t state, state_nxt;
    logic   accept, finish;

    logic [IN_WIDTH-1:0] op_sum, op_diff;
    logic [MAG_W-1:0]    sum_ext, diff_ext, sum_mag, diff_mag;
    logic                sum_zero, too_big;

    logic [REM_W-1:0]     rem;
    logic [MAG_W-1:0]     divisor;
    logic [QUO_W-1:0]     quot;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 iter_done, neg, sat_q, div0_q;

    logic                  ge;
    logic [REM_W-1:0]      rem_sub;
    logic [DATA_WIDTH-1:0] q_ext, q_signed, q_final;
    logic [31:0]           out_word;

    assign op_sum  = S_AXIS_in_tdata[2*IN_WIDTH-1:IN_WIDTH];
    assign op_diff = S_AXIS_in_tdata[IN_WIDTH-1:0];

    // One extra bit so that the magnitude of the most negative operand is exact.
    assign diff_ext = {op_diff[IN_WIDTH-1], op_diff};
    assign sum_ext  = {op_sum[IN_WIDTH-1], op_sum};
    assign diff_mag = diff_ext[MAG_W-1] ? ((~diff_ext) + MAG_W'(1)) : diff_ext;
    assign sum_mag  = sum_ext[MAG_W-1]  ? ((~sum_ext) + MAG_W'(1))  : sum_ext;
    assign sum_zero = (op_sum == '0);
    assign too_big  = ({1'b0, diff_mag} >= {sum_mag, 1'b0});

    assign ge      = (rem >= {1'b0, divisor});
    assign rem_sub = ge ? (rem - {1'b0, divisor}) : rem;

    // Two's complement of a zero magnitude is zero, so no negative zero can appear.
    assign q_ext    = {{(DATA_WIDTH-QUO_W){1'b0}}, quot};
    assign q_signed = neg ? ((~q_ext) + DATA_WIDTH'(1)) : q_ext;
    assign q_final  = sat_q ? (neg ? Q_MIN : Q_MAX) : q_signed;
    assign out_word = {{(32-DATA_WIDTH){q_final[DATA_WIDTH-1]}}, q_final};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would infer a latch.
        state_nxt        = state;
        accept           = 1'b0;
        finish           = 1'b0;
        S_AXIS_in_tready = 1'b0;
        case (state)
            IDLE: begin
                S_AXIS_in_tready = rst;
                if (S_AXIS_in_tvalid && rst) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (iter_done) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, so an aborted division
        // leaves nothing behind that a later result could pick up.
        if (!rst) begin
            rem               <= '0;
            divisor           <= '0;
            quot              <= '0;
            cnt               <= '0;
            iter_done         <= 1'b0;
            neg               <= 1'b0;
            sat_q             <= 1'b0;
            div0_q            <= 1'b0;
            M_AXIS_out_tdata  <= '0;
            M_AXIS_out_tvalid <= 1'b0;
            sat_flag          <= 1'b0;
            div0_flag         <= 1'b0;
        end else begin
            M_AXIS_out_tvalid <= finish;
            if (accept) begin
                rem       <= {1'b0, diff_mag};
                divisor   <= sum_mag;
                quot      <= '0;
                cnt       <= CNT_INIT;
                iter_done <= 1'b0;
                neg       <= op_diff[IN_WIDTH-1] ^ op_sum[IN_WIDTH-1];
                sat_q     <= sum_zero | too_big;
                div0_q    <= sum_zero;
            end else if (state == CALC && !iter_done) begin
                // Iterations still run when saturating, keeping latency constant.
                quot <= {quot[QUO_W-2:0], ge};
                rem  <= {rem_sub[REM_W-2:0], 1'b0};
                if (cnt == '0) iter_done <= 1'b1;
                else           cnt       <= cnt - CNT_WIDTH'(1);
            end
            if (finish) begin
                M_AXIS_out_tdata <= out_word;
                sat_flag         <= sat_q;
                div0_flag        <= div0_q;
            end
        end
    end

endmodule
